// File: rtl/rv32imf_wfi_sleep_ctrl.sv
// rtl/rv32imf_wfi_sleep_ctrl.sv - WFI low-power sequencer: drain, clock gate, wake settle, done pulse
// Also keeps a saturating count of gated cycles for performance monitoring.
module rv32imf_wfi_sleep_ctrl #(
  parameter int WAKE_CYCLES = 2,
  parameter int CNT_W       = 32
) (
  input  logic             clk_i,
  input  logic             rst_n,
  input  logic             wfi_req_i,
  input  logic             debug_mode_i,
  input  logic             core_busy_i,
  input  logic             irq_pending_i,
  input  logic             debug_req_i,
  input  logic             cnt_clr_i,
  output logic             clock_en_o,
  output logic             fetch_halt_o,
  output logic             sleeping_o,
  output logic             wfi_done_o,
  output logic [CNT_W-1:0] sleep_cycles_o
);

  localparam int WCW = (WAKE_CYCLES > 1) ? $clog2(WAKE_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_RUN   = 3'd0,
    S_DRAIN = 3'd1,
    S_SLEEP = 3'd2,
    S_WAKE  = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [WCW-1:0]   wcnt_q, wcnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wake_evt;

  assign wake_evt = irq_pending_i | debug_req_i;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_RUN;
      wcnt_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      S_RUN: begin
        if (wfi_req_i) state_d = debug_mode_i ? S_DONE : S_DRAIN;
      end
      // A wake arriving while draining aborts the WFI as a NOP.
      S_DRAIN: begin
        if (wake_evt)          state_d = S_DONE;
        else if (!core_busy_i) state_d = S_SLEEP;
      end
      S_SLEEP: begin
        if (wake_evt) begin
          state_d = S_WAKE;
          wcnt_d  = WCW'(WAKE_CYCLES - 1);
        end
      end
      S_WAKE: begin
        if (wcnt_q == '0) state_d = S_DONE;
        else              wcnt_d  = wcnt_q - 1'b1;
      end
      S_DONE:  state_d = S_RUN;
      default: state_d = S_RUN;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr_i)                                         cnt_d = '0;
    else if (state_q == S_SLEEP && cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + 1'b1;
  end

  // Clock enable follows wake_evt combinationally in SLEEP so the core restarts in the wake cycle.
  always_comb begin
    clock_en_o   = 1'b1;
    fetch_halt_o = 1'b0;
    sleeping_o   = 1'b0;
    wfi_done_o   = 1'b0;
    case (state_q)
      S_DRAIN: fetch_halt_o = 1'b1;
      S_SLEEP: begin
        clock_en_o   = wake_evt;
        fetch_halt_o = 1'b1;
        sleeping_o   = 1'b1;
      end
      S_WAKE:  fetch_halt_o = 1'b1;
      S_DONE:  wfi_done_o   = 1'b1;
      default: ;
    endcase
  end

  assign sleep_cycles_o = cnt_q;

endmodule

// File: tb/tb_rv32imf_wfi_sleep_ctrl.sv
// tb/tb_rv32imf_wfi_sleep_ctrl.sv - vector table, directed corner sequences and randomized model check
module tb_rv32imf_wfi_sleep_ctrl;

  localparam int WAKE_CYCLES = 2;
  localparam int CNT_W       = 4;
  localparam int CNT_MAX     = 15;

  logic clk_i = 1'b0;
  logic rst_n = 1'b0;
  logic wfi_req_i = 0, debug_mode_i = 0, core_busy_i = 0;
  logic irq_pending_i = 0, debug_req_i = 0, cnt_clr_i = 0;
  logic clock_en_o, fetch_halt_o, sleeping_o, wfi_done_o;
  logic [CNT_W-1:0] sleep_cycles_o;

  int n_cmp = 0;
  int n_bad = 0;

  rv32imf_wfi_sleep_ctrl #(.WAKE_CYCLES(WAKE_CYCLES), .CNT_W(CNT_W)) dut (
    .clk_i(clk_i), .rst_n(rst_n), .wfi_req_i(wfi_req_i), .debug_mode_i(debug_mode_i),
    .core_busy_i(core_busy_i), .irq_pending_i(irq_pending_i), .debug_req_i(debug_req_i),
    .cnt_clr_i(cnt_clr_i), .clock_en_o(clock_en_o), .fetch_halt_o(fetch_halt_o),
    .sleeping_o(sleeping_o), .wfi_done_o(wfi_done_o), .sleep_cycles_o(sleep_cycles_o)
  );

  always #5 clk_i = ~clk_i;

  // inputs: {wfi, dbg_mode, busy, irq, dbg_req, clr}; expected: {clk_en, halt, sleeping, done, cnt}
  typedef struct packed {
    logic [5:0] in;
    logic [3:0] flags;
    logic [3:0] cnt;
  } vec_t;

  // Reference model: phase of the WFI, remaining settle cycles, cycles slept.
  localparam int P_IDLE = 0, P_DRAIN = 1, P_GATED = 2, P_SETTLE = 3, P_DONE = 4;
  int m_phase = P_IDLE;
  int m_left  = 0;
  int m_slept = 0;

  function automatic logic [7:0] actual();
    return {clock_en_o, fetch_halt_o, sleeping_o, wfi_done_o, sleep_cycles_o};
  endfunction

  function automatic logic [7:0] model_out(input logic [5:0] in);
    logic wake;
    logic [3:0] f;
    wake = in[2] | in[1];
    f[3] = (m_phase != P_GATED) || wake;
    f[2] = (m_phase == P_DRAIN) || (m_phase == P_GATED) || (m_phase == P_SETTLE);
    f[1] = (m_phase == P_GATED);
    f[0] = (m_phase == P_DONE);
    return {f, 4'(m_slept)};
  endfunction

  task automatic model_step(input logic [5:0] in);
    logic wake;
    int next;
    wake = in[2] | in[1];
    next = m_phase;
    if (in[0]) m_slept = 0;
    else if (m_phase == P_GATED) m_slept = (m_slept + 1 > CNT_MAX) ? CNT_MAX : m_slept + 1;
    case (m_phase)
      P_IDLE:   if (in[5]) next = in[4] ? P_DONE : P_DRAIN;
      P_DRAIN:  if (wake) next = P_DONE; else if (!in[3]) next = P_GATED;
      P_GATED:  if (wake) begin next = P_SETTLE; m_left = WAKE_CYCLES; end
      P_SETTLE: begin m_left = m_left - 1; if (m_left == 0) next = P_DONE; end
      default:  next = P_IDLE;
    endcase
    m_phase = next;
  endtask

  task automatic model_reset();
    m_phase = P_IDLE; m_left = 0; m_slept = 0;
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got en/halt/slp/done=%b cnt=%0d, want %b cnt=%0d",
               name, act[7:4], act[3:0], exp[7:4], exp[3:0]);
    end
  endtask

  task automatic set_in(input logic [5:0] in);
    {wfi_req_i, debug_mode_i, core_busy_i, irq_pending_i, debug_req_i, cnt_clr_i} = in;
  endtask

  // Inputs applied 1 after the edge, outputs sampled 4 after the edge, model advanced on the edge.
  task automatic cycle(input string name, input logic [5:0] in);
    set_in(in);
    #3;
    check(name, actual(), model_out(in));
    @(posedge clk_i);
    model_step(in);
    #1;
  endtask

  vec_t tbl[$];

  initial begin
    tbl = '{
      '{6'b110000, 4'b1000, 4'd0},  // debug NOP: RUN
      '{6'b110000, 4'b1001, 4'd0},  // DONE, request ignored
      '{6'b000000, 4'b1000, 4'd0},
      '{6'b101000, 4'b1000, 4'd0},  // basic sleep
      '{6'b101000, 4'b1100, 4'd0},
      '{6'b101000, 4'b1100, 4'd0},
      '{6'b100000, 4'b1100, 4'd0},
      '{6'b100000, 4'b0110, 4'd0},
      '{6'b100000, 4'b0110, 4'd1},
      '{6'b100100, 4'b1110, 4'd2},  // irq: clock back in same cycle
      '{6'b100100, 4'b1100, 4'd3},
      '{6'b100000, 4'b1100, 4'd3},
      '{6'b100000, 4'b1001, 4'd3},
      '{6'b101000, 4'b1000, 4'd3},  // request held past DONE
      '{6'b101000, 4'b1100, 4'd3},
      '{6'b100100, 4'b1100, 4'd3},  // busy falls with irq: abort
      '{6'b000000, 4'b1001, 4'd3},
      '{6'b000000, 4'b1000, 4'd3},
      '{6'b000000, 4'b1000, 4'd3},
      '{6'b100000, 4'b1000, 4'd3},
      '{6'b100000, 4'b1100, 4'd3},
      '{6'b100001, 4'b0110, 4'd3},  // clear in SLEEP
      '{6'b100010, 4'b1110, 4'd0},  // debug request wakes
      '{6'b100000, 4'b1100, 4'd1},
      '{6'b100000, 4'b1100, 4'd1},
      '{6'b000000, 4'b1001, 4'd1},
      '{6'b000000, 4'b1000, 4'd1}
    };

    rst_n = 1'b0;
    set_in(6'b0);
    #3;
    check("reset_values", actual(), 8'b1000_0000);
    repeat (2) @(posedge clk_i);
    #1 rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      set_in(tbl[i].in);
      #3;
      check($sformatf("vec%0d", i), actual(), {tbl[i].flags, tbl[i].cnt});
      @(posedge clk_i);
      #1;
    end

    // Saturation: 20 gated cycles on a 4-bit counter, then clear while still asleep.
    rst_n = 1'b0; model_reset(); #1 rst_n = 1'b1;
    @(posedge clk_i); #1;
    cycle("sat_req", 6'b100000);
    cycle("sat_drain", 6'b100000);
    for (int i = 0; i < 20; i++) cycle($sformatf("sat_sleep%0d", i), 6'b100000);
    check("sat_hold", actual(), 8'b0110_1111);
    cycle("clr", 6'b100001);
    for (int i = 0; i < 3; i++) cycle($sformatf("after_clr%0d", i), 6'b100000);
    check("clr_count", {4'b0, sleep_cycles_o}, 8'd3);

    // Asynchronous reset mid-sleep: outputs must change with no clock edge.
    set_in(6'b100000);
    #1 rst_n = 1'b0;
    #1 check("async_rst", actual(), 8'b1000_0000);
    model_reset();
    @(posedge clk_i); #1 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) cycle($sformatf("idle%0d", i), 6'b000000);

    // Randomized run against the model; requester holds wfi until done is seen.
    begin
      logic wfi = 0, dbgm = 0, hold_req = 0;
      int irq_left = 0;
      logic irq;
      for (int c = 0; c < 3000; c++) begin
        logic [5:0] in;
        if (!wfi && $urandom_range(3) == 0) begin
          wfi = 1; dbgm = ($urandom_range(7) == 0);
        end
        if (irq_left == 0 && $urandom_range(11) == 0) irq_left = $urandom_range(6, 1);
        irq = (irq_left > 0);
        if (irq_left > 0) irq_left--;
        in = {wfi, dbgm, logic'($urandom_range(2) != 0), irq,
              logic'($urandom_range(39) == 0), logic'($urandom_range(29) == 0)};
        hold_req = (m_phase == P_DONE);
        cycle($sformatf("rnd%0d", c), in);
        if (hold_req && $urandom_range(1) == 0) wfi = 0;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
